// File: rtl/gshare_predictor.sv
// Gshare/bimodal branch direction predictor: a table of 2-bit saturating counters,
// indexed by PC (optionally XOR global history), with speculative GHR and mispredict repair.
module gshare_predictor #(
  parameter int unsigned PC_WIDTH  = 64,
  parameter int unsigned IDX_WIDTH = 8,
  parameter int unsigned GHR_WIDTH = 8,
  parameter int unsigned MODE      = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 init_done,
  input  logic                 pred_req,
  input  logic [PC_WIDTH-1:0]  pred_pc,
  output logic                 pred_valid,
  output logic                 pred_taken,
  output logic [GHR_WIDTH-1:0] pred_ghr,
  input  logic                 upd_valid,
  input  logic [PC_WIDTH-1:0]  upd_pc,
  input  logic [GHR_WIDTH-1:0] upd_ghr,
  input  logic                 upd_taken,
  input  logic                 upd_mispredict
);

  localparam int unsigned Entries = 2 ** IDX_WIDTH;

  typedef enum logic [0:0] {StInit, StReady} state_e;

  state_e               state_q, state_d;
  logic [IDX_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic [GHR_WIDTH-1:0] ghr_q, ghr_d;
  logic [1:0]           pht_q [Entries];
  logic                 pred_valid_q, pred_taken_q;
  logic [GHR_WIDTH-1:0] pred_ghr_q;

  logic                 ready, pred_fire, upd_fire, pred_bit;
  logic [IDX_WIDTH-1:0] pred_idx, upd_idx;
  logic [1:0]           upd_ctr, upd_ctr_next;

  // Only pc[IDX_WIDTH+1:2] feeds the index; the rest of the PC is intentionally ignored.
  logic unused_pc;
  assign unused_pc = ^{pred_pc, upd_pc};

  function automatic logic [IDX_WIDTH-1:0] pht_index(input logic [PC_WIDTH-1:0]  pc,
                                                     input logic [GHR_WIDTH-1:0] ghr);
    if (MODE == 1) return pc[IDX_WIDTH+1:2] ^ IDX_WIDTH'(ghr);
    return pc[IDX_WIDTH+1:2];
  endfunction

  always_comb begin
    ready     = (state_q == StReady);
    pred_fire = ready & pred_req;
    upd_fire  = ready & upd_valid;
    pred_idx  = pht_index(pred_pc, ghr_q);
    upd_idx   = pht_index(upd_pc, upd_ghr);
    pred_bit  = pht_q[pred_idx][1];
    upd_ctr   = pht_q[upd_idx];
    if (upd_taken) begin
      upd_ctr_next = (upd_ctr == 2'b11) ? 2'b11 : upd_ctr + 2'd1;
    end else begin
      upd_ctr_next = (upd_ctr == 2'b00) ? 2'b00 : upd_ctr - 2'd1;
    end
  end

  // Truncating {ghr, bit} keeps the low GHR_WIDTH bits, which also covers GHR_WIDTH == 1.
  always_comb begin
    ghr_d = ghr_q;
    if (pred_fire) ghr_d = GHR_WIDTH'({ghr_q, pred_bit});
    if (upd_fire && upd_mispredict) ghr_d = GHR_WIDTH'({upd_ghr, upd_taken});
  end

  // FSM: next-state logic
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    unique case (state_q)
      StInit: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (&init_cnt_q) state_d = StReady;
      end
      StReady: ;
      default: state_d = StInit;
    endcase
  end

  // FSM: outputs
  always_comb begin
    init_done = (state_q == StReady);
  end

  // FSM: state register plus response pipeline
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StInit;
      init_cnt_q   <= '0;
      ghr_q        <= '0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_ghr_q   <= '0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      ghr_q        <= ghr_d;
      pred_valid_q <= pred_fire;
      if (pred_fire) begin
        pred_taken_q <= pred_bit;
        pred_ghr_q   <= ghr_q;
      end
    end
  end

  // Reads above use the pre-edge table, so a same-cycle update never bypasses into a prediction.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state_q == StInit) begin
        pht_q[init_cnt_q] <= 2'b01;
      end else if (upd_fire) begin
        pht_q[upd_idx] <= upd_ctr_next;
      end
    end
  end

  assign pred_valid = pred_valid_q;
  assign pred_taken = pred_taken_q;
  assign pred_ghr   = pred_ghr_q;

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor (IDX_WIDTH=4, GHR_WIDTH=4); a second MODE=0 instance
// shares the stimulus and is checked only for the bimodal indexing case.
module tb_gshare_predictor;

  logic        clock, reset;
  logic        pred_req, upd_valid, upd_taken, upd_mispredict;
  logic [63:0] pred_pc, upd_pc;
  logic [3:0]  upd_ghr;
  logic        init_done, pred_valid, pred_taken;
  logic [3:0]  pred_ghr;
  logic        init_done_b, pred_valid_b, pred_taken_b;
  logic [3:0]  pred_ghr_b;

  int checks = 0;
  int errors = 0;

  gshare_predictor #(.PC_WIDTH(64), .IDX_WIDTH(4), .GHR_WIDTH(4), .MODE(1)) dut (
    .clock(clock), .reset(reset), .init_done(init_done),
    .pred_req(pred_req), .pred_pc(pred_pc), .pred_valid(pred_valid),
    .pred_taken(pred_taken), .pred_ghr(pred_ghr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr),
    .upd_taken(upd_taken), .upd_mispredict(upd_mispredict)
  );

  gshare_predictor #(.PC_WIDTH(64), .IDX_WIDTH(4), .GHR_WIDTH(4), .MODE(0)) dut_bim (
    .clock(clock), .reset(reset), .init_done(init_done_b),
    .pred_req(pred_req), .pred_pc(pred_pc), .pred_valid(pred_valid_b),
    .pred_taken(pred_taken_b), .pred_ghr(pred_ghr_b),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr),
    .upd_taken(upd_taken), .upd_mispredict(upd_mispredict)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    pred_req = 0; pred_pc = '0;
    upd_valid = 0; upd_pc = '0; upd_ghr = '0; upd_taken = 0; upd_mispredict = 0;
  endtask

  task automatic predict(input logic [63:0] pc);
    pred_req = 1; pred_pc = pc;
    step();
    pred_req = 0;
  endtask

  task automatic update(input logic [63:0] pc, input logic [3:0] ghr, input logic tk,
                        input logic mis);
    upd_valid = 1; upd_pc = pc; upd_ghr = ghr; upd_taken = tk; upd_mispredict = mis;
    step();
    upd_valid = 0; upd_mispredict = 0;
  endtask

  // Counts edges until init_done rises; a response during INIT is recorded as an error.
  task automatic wait_init(input string tag);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    while (init_done !== 1'b1 && n < 64) begin
      step();
      n++;
      if (pred_valid === 1'b1) seen = 1;
    end
    check_eq(tag, n, 16);
    check_eq({tag, "_no_resp"}, seen, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset = 1;
    step();
    check_eq("rst_init_done", init_done, 0);
    check_eq("rst_pred_valid", pred_valid, 0);
    check_eq("rst_pred_taken", pred_taken, 0);
    check_eq("rst_pred_ghr", pred_ghr, 0);
    reset = 0;
    wait_init("init_len");
    check_eq("init_done", init_done, 1);

    // First prediction from a freshly initialised table
    predict(64'h40);
    check_eq("p1_valid", pred_valid, 1);
    check_eq("p1_taken", pred_taken, 0);
    check_eq("p1_ghr", pred_ghr, 4'b0000);
    step();
    check_eq("p1_valid_drop", pred_valid, 0);

    // Train entry 0 taken three times, 01->10->11->11
    update(64'h40, 4'b0000, 1, 0);
    update(64'h40, 4'b0000, 1, 0);
    update(64'h40, 4'b0000, 1, 0);
    predict(64'h40);
    check_eq("sat_taken", pred_taken, 1);
    check_eq("sat_ghr", pred_ghr, 4'b0000);

    // GHR=0001: pc 0x40 -> idx 1; same-cycle update of idx 1 must not bypass
    pred_req = 1; pred_pc = 64'h40;
    upd_valid = 1; upd_pc = 64'h44; upd_ghr = 4'b0000; upd_taken = 1;
    step();
    idle();
    check_eq("rw_pre_taken", pred_taken, 0);
    check_eq("rw_pre_ghr", pred_ghr, 4'b0001);
    predict(64'h4C);  // GHR=0010, idx 3^2 = 1, counter now 10
    check_eq("rw_post_taken", pred_taken, 1);
    check_eq("rw_post_ghr", pred_ghr, 4'b0010);

    // GHR=0101; plain update must leave it alone
    update(64'h4C, 4'b0000, 1, 0);  // entry 3 -> 10
    predict(64'h40);
    check_eq("noupd_ghr", pred_ghr, 4'b0101);
    update(64'h3C, 4'b0000, 0, 1);  // mispredict repair -> GHR 0000

    // Speculative history chain through taken entries 0,1,3
    pred_req = 1; pred_pc = 64'h40;
    step();
    check_eq("chain0_taken", pred_taken, 1);
    check_eq("chain0_ghr", pred_ghr, 4'b0000);
    step();
    check_eq("chain1_taken", pred_taken, 1);
    check_eq("chain1_ghr", pred_ghr, 4'b0001);
    step();
    check_eq("chain2_taken", pred_taken, 1);
    check_eq("chain2_ghr", pred_ghr, 4'b0011);
    upd_valid = 1; upd_pc = 64'h40; upd_ghr = 4'b0001; upd_taken = 0; upd_mispredict = 1;
    step();
    check_eq("chain3_taken", pred_taken, 0);
    check_eq("chain3_ghr", pred_ghr, 4'b0111);
    upd_valid = 0; upd_mispredict = 0;
    step();
    check_eq("repair_ghr", pred_ghr, 4'b0010);
    idle();

    // Reset during READY discards the in-flight prediction
    pred_req = 1; pred_pc = 64'h40;
    reset = 1;
    step();
    idle();
    check_eq("rst2_pred_valid", pred_valid, 0);
    check_eq("rst2_init_done", init_done, 0);
    check_eq("rst2_pred_ghr", pred_ghr, 0);
    reset = 0;
    repeat (7) step();
    check_eq("cnt_at_7", dut.init_cnt_q, 7);
    reset = 1;
    step();
    check_eq("cnt_reset", dut.init_cnt_q, 0);
    reset = 0;
    // Requests and updates held during INIT must be ignored
    pred_req = 1; pred_pc = 64'h40;
    upd_valid = 1; upd_pc = 64'h40; upd_ghr = 4'b0000; upd_taken = 1;
    wait_init("reinit_len");
    idle();
    predict(64'h40);
    check_eq("reinit_taken", pred_taken, 0);
    check_eq("reinit_ghr", pred_ghr, 4'b0000);

    // Bimodal: upd_ghr is ignored, both updates land on entry 1
    update(64'h44, 4'b1111, 1, 0);
    predict(64'h44);
    check_eq("bim_valid", pred_valid_b, 1);
    check_eq("bim_taken", pred_taken_b, 1);
    update(64'h44, 4'b0000, 0, 0);
    predict(64'h44);
    check_eq("bim_back_nt", pred_taken_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
